ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction-fetch front end that produces the `{instr, en}` stream consumed by the decode stage.
- Owns the fetch PC and issues 32-bit aligned fetch requests on a valid/ready I-side port.
- Accepts in-order responses and buffers them with their PC in a DEPTH-entry FIFO.
- Presents the FIFO head to decode over a valid/ready handshake. Handles pipeline redirects, including discarding in-flight stale responses, and converts fetch faults into tagged entries.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight credit; power of two, ≥2.
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous assert, active-low.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  64  new fetch PC.
- fetch_req_valid  out  1  fetch request valid.
- fetch_req_ready  in  1  memory accepts the request.
- fetch_req_addr  out  64  request byte address (equals the fetch PC).
- fetch_resp_valid  in  1  response valid; responses return in request order, one per cycle maximum.
- fetch_resp_data  in  32  instruction word.
- fetch_resp_err  in  1  access fault for this response.
- out_valid  out  1  head entry valid; drives decoder en.
- out_ready  in  1  decode consumes the head.
- out_instr  out  32  head instruction; 0 on a fault entry.
- out_pc  out  64  head PC.
- out_fault  out  2  0 = none, 1 = instruction-address-misaligned, 2 = instruction-access-fault.

Behaviour:
- Reset values
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; state = RUN.
  - All outputs 0 while rst_n is low.
  - Reset mid-operation abandons all in-flight requests. The memory side is reset by the same rst_n.
- States
  - RUN: fetching.
  - HALT: a fault entry has been queued; no requests are issued until a redirect.
- Request issue
  - fetch_req_valid = RUN & fetch_pc[1:0]==0 & (count + outstanding < DEPTH) & !redirect_valid.
  - On handshake: fetch_pc += 4 (64-bit wrap); outstanding += 1.
  - Request is combinational from registered state. The first request appears the cycle after rst_n deasserts, with address RESET_PC.
- Response handling
  - Each response decrements outstanding.
  - If discard > 0: the response is dropped and discard decrements.
  - Otherwise: push {fetch_resp_data, pc, fault}. The pc comes from an internal in-order PC shadow, or equivalently resp_pc = fetch_pc − 4·(outstanding).
  - If fetch_resp_err: push with out_instr = 0 and fault = 2, then go to HALT. discard = outstanding − 1, so all younger responses are dropped.
- Misaligned PC
  - Applies in RUN when fetch_pc[1:0]≠0.
  - No request is issued. Once outstanding == 0 and the FIFO is not full, push {0, fetch_pc, fault=1} and go to HALT.
- Output
  - out_valid = count≠0 & !redirect_valid.
  - Pop on out_valid & out_ready.
  - Latency: response at cycle r → out_valid at r+1.
  - Push and pop in the same cycle on a full FIFO are both legal. The credit rule guarantees no overflow; overflow is an assertion failure.
- Redirect
  - Takes priority over every other event in its cycle.
  - Next cycle: FIFO empty, fetch_pc = redirect_pc, state = RUN.
  - discard = outstanding + (request handshake this cycle ? 1 : 0) − (response this cycle ? 1 : 0 if it was not itself being discarded), applied on top of any existing discard count.
  - No pop occurs in the redirect cycle.
  - fetch_req_valid rises the cycle after the redirect, with addr = redirect_pc.
- Counters
  - count and outstanding are each log2(DEPTH)+1 bits.
  - discard ≤ DEPTH.
  - FIFO pointers wrap modulo DEPTH.

Test Plan:
1. Stream, always-ready memory with 1-cycle response, out_ready=1 → requests at 0x8000_0000, 0x8000_0004, …; out_pc follows the same sequence with out_instr equal to the returned data; no bubbles after fill.
2. Backpressure: out_ready=0 with DEPTH=4 → exactly 4 requests accepted, then fetch_req_valid=0. Raise out_ready → one new request per pop.
3. Redirect to 0x8000_1000 with 3 responses in flight → those 3 are dropped, FIFO is empty the next cycle, the first out_pc after recovery is 0x8000_1000.
4. Redirect to 0x8000_1002 → no request issued; one entry with out_pc=0x8000_1002 and out_fault=1; then idle in HALT until the next redirect.
5. Second response of a 4-request burst returns fetch_resp_err → entries pc0 (fault 0) then pc0+4 (fault 2); the remaining 2 responses are dropped; no further requests are issued.
6. Simultaneous redirect, response arrival and out_ready=1 on a full FIFO → no pop, no push, and the discard count is correct. Then assert rst_n=0 mid-burst → all outputs 0 immediately; after release the first request is at RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch front end with a PC-tagged response FIFO
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_req_valid,
    input  logic        fetch_req_ready,
    output logic [63:0] fetch_req_addr,
    input  logic        fetch_resp_valid,
    input  logic [31:0] fetch_resp_data,
    input  logic        fetch_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic [1:0]  out_fault
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t        state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   outstanding_q, outstanding_d;
    logic [AW:0]   discard_q, discard_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;

    logic [31:0]   instr_mem [DEPTH];
    logic [63:0]   pc_mem    [DEPTH];
    logic [1:0]    fault_mem [DEPTH];

    logic [AW+1:0] credit_used;
    logic          aligned, head_valid, req_fire, resp_keep, mis_push, push, pop;
    logic [63:0]   resp_pc;
    logic [31:0]   push_instr;
    logic [63:0]   push_pc;
    logic [1:0]    push_fault;

    always_comb begin
        aligned     = fetch_pc_q[1:0] == 2'b00;
        credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
        head_valid  = count_q != '0;

        // Gated by rst_n so the request port is quiet while reset is held.
        fetch_req_valid = rst_n && (state_q == RUN) && aligned &&
                          (credit_used < (AW+2)'(DEPTH)) && !redirect_valid;
        fetch_req_addr  = rst_n ? fetch_pc_q : '0;
        req_fire        = fetch_req_valid && fetch_req_ready;

        resp_keep = fetch_resp_valid && (discard_q == '0);
        mis_push  = (state_q == RUN) && !aligned && (outstanding_q == '0) && (count_q != DEPTH_C);
        push      = !redirect_valid && (resp_keep || mis_push);

        out_valid = head_valid && !redirect_valid;
        pop       = out_valid && out_ready;
        out_instr = head_valid ? instr_mem[rd_ptr_q] : '0;
        out_pc    = head_valid ? pc_mem[rd_ptr_q]    : '0;
        out_fault = head_valid ? fault_mem[rd_ptr_q] : '0;

        // Responses are in order, so the oldest live request sits outstanding words behind fetch_pc.
        resp_pc = fetch_pc_q - 64'({outstanding_q, 2'b00});
        if (resp_keep) begin
            push_instr = fetch_resp_err ? 32'd0 : fetch_resp_data;
            push_pc    = resp_pc;
            push_fault = fetch_resp_err ? 2'd2 : 2'd0;
        end else begin
            push_instr = 32'd0;
            push_pc    = fetch_pc_q;
            push_fault = 2'd1;
        end

        outstanding_d = outstanding_q + (AW+1)'(req_fire) - (AW+1)'(fetch_resp_valid);
        state_d       = state_q;
        discard_d     = discard_q;
        fetch_pc_d    = req_fire ? fetch_pc_q + 64'd4 : fetch_pc_q;
        count_d       = count_q + (AW+1)'(push) - (AW+1)'(pop);

        if (redirect_valid) begin
            // Everything still in flight after this cycle is stale.
            state_d    = RUN;
            discard_d  = outstanding_d;
            fetch_pc_d = redirect_pc;
            count_d    = '0;
        end else if (resp_keep && fetch_resp_err) begin
            state_d   = HALT;
            discard_d = outstanding_d;
        end else if (mis_push) begin
            state_d = HALT;
        end else if (fetch_resp_valid && !resp_keep) begin
            discard_d = discard_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            assert (!(push && !pop && count_q == DEPTH_C));
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= push_instr;
            pc_mem[wr_ptr_q]    <= push_pc;
            fault_mem[wr_ptr_q] <= push_fault;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed and randomized checks of ifetch_queue against a program-order model
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [63:0] NO_ERR   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        fetch_req_valid;
    logic        fetch_req_ready = 1'b0;
    logic [63:0] fetch_req_addr;
    logic        fetch_resp_valid = 1'b0;
    logic [31:0] fetch_resp_data = '0;
    logic        fetch_resp_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [1:0]  out_fault;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_req_addr(fetch_req_addr),
        .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data),
        .fetch_resp_err(fetch_resp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_fault(out_fault)
    );

    typedef struct { logic [63:0] addr; int rdy; } pend_t;
    pend_t       pend[$];
    int          tests = 0, fails = 0, cyc = 0;
    int          pops = 0, total_pops = 0, req_fires = 0, resp_rand = 0;
    logic        resp_hold = 1'b0, halted = 1'b0;
    logic [63:0] err_pc = NO_ERR, exp_pc, req_pc, first_pc, rpc;

    function automatic logic [31:0] data_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_restart(input logic [63:0] pc);
        exp_pc = pc;
        req_pc = pc;
        halted = 1'b0;
    endtask

    task automatic mark();
        pops      = 0;
        req_fires = 0;
        first_pc  = NO_ERR;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req_valid"}, fetch_req_valid, 0);
        check({tag, "_req_addr"},  fetch_req_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_instr"}, out_instr, 0);
        check({tag, "_out_pc"},    out_pc, 0);
        check({tag, "_out_fault"}, out_fault, 0);
    endtask

    // Expected head: the program-order word at exp_pc, or the fault that ends the stream there.
    task automatic score_pop();
        logic [1:0]  efault;
        logic [31:0] einstr;
        pops++;
        total_pops++;
        if (pops == 1) first_pc = out_pc;
        if (halted) begin
            check("pop_after_fault", out_valid, 0);
        end else begin
            efault = (exp_pc[1:0] != 2'b00) ? 2'd1 : (exp_pc == err_pc) ? 2'd2 : 2'd0;
            einstr = (efault != 2'd0) ? 32'd0 : data_of(exp_pc);
            check("out_pc", out_pc, exp_pc);
            check("out_instr", out_instr, einstr);
            check("out_fault", out_fault, efault);
            if (efault != 2'd0) halted = 1'b1;
            exp_pc = exp_pc + 64'd4;
        end
    endtask

    // One clock: drive inputs after the falling edge, observe handshakes, then cross the rising edge.
    task automatic step(input logic redir, input logic [63:0] rpc_in);
        redirect_valid   = redir;
        redirect_pc      = rpc_in;
        fetch_resp_valid = 1'b0;
        fetch_resp_data  = '0;
        fetch_resp_err   = 1'b0;
        if (!resp_hold && pend.size() > 0) begin
            if (pend[0].rdy <= cyc && (resp_rand == 0 || $urandom_range(0, 99) < resp_rand)) begin
                fetch_resp_valid = 1'b1;
                fetch_resp_data  = data_of(pend[0].addr);
                fetch_resp_err   = (pend[0].addr == err_pc);
            end
        end
        #1;
        if (redir) check("redirect_no_pop", out_valid, 0);
        if (fetch_req_valid && fetch_req_ready) begin
            check("req_addr", fetch_req_addr, req_pc);
            check("req_aligned", fetch_req_addr[1:0], 0);
            pend.push_back('{fetch_req_addr, cyc + 1});
            req_pc = req_pc + 64'd4;
            req_fires++;
        end
        if (fetch_resp_valid) void'(pend.pop_front());
        if (out_valid && out_ready) score_pop();
        if (redir) model_restart(rpc_in);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_quiet("reset");
        rst_n = 1'b1;
        model_restart(RESET_PC);
        #1;
        check("first_req_valid", fetch_req_valid, 1);
        check("first_req_addr", fetch_req_addr, RESET_PC);

        // Streaming with an always-ready memory and consumer.
        fetch_req_ready = 1'b1;
        out_ready       = 1'b1;
        mark();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0);
            if (i >= 2) check("stream_no_bubble", out_valid, 1);
        end
        check("stream_first_pc", first_pc, RESET_PC);

        // Backpressure: credit stops issue at DEPTH, then one request per pop.
        out_ready = 1'b0;
        mark();
        step(1'b1, 64'h8000_2000);
        repeat (10) step(1'b0, '0);
        check("bp_req_count", req_fires, DEPTH);
        check("bp_req_stalled", fetch_req_valid, 0);
        out_ready = 1'b1;
        mark();
        step(1'b0, '0);
        out_ready = 1'b0;
        repeat (4) step(1'b0, '0);
        check("bp_one_per_pop", req_fires, 1);

        // Redirect with three responses in flight.
        fetch_req_ready = 1'b0;
        out_ready       = 1'b1;
        repeat (6) step(1'b0, '0);
        resp_hold = 1'b1;
        step(1'b1, 64'h8000_0200);
        fetch_req_ready = 1'b1;
        mark();
        repeat (3) step(1'b0, '0);
        check("inflight_count", req_fires, 3);
        step(1'b1, 64'h8000_1000);
        check("redirect_empty", out_valid, 0);
        resp_hold = 1'b0;
        mark();
        repeat (10) step(1'b0, '0);
        check("redirect_first_pc", first_pc, 64'h8000_1000);

        // Misaligned redirect target.
        mark();
        step(1'b1, 64'h8000_1002);
        repeat (8) step(1'b0, '0);
        check("mis_no_req", req_fires, 0);
        check("mis_one_entry", pops, 1);
        check("mis_entry_pc", first_pc, 64'h8000_1002);
        check("mis_halt_out", out_valid, 0);
        check("mis_halt_req", fetch_req_valid, 0);

        // Access fault on the second response of a four-request burst.
        out_ready = 1'b0;
        resp_hold = 1'b1;
        err_pc    = 64'h8000_3004;
        mark();
        step(1'b1, 64'h8000_3000);
        repeat (5) step(1'b0, '0);
        check("err_burst", req_fires, DEPTH);
        resp_hold = 1'b0;
        repeat (6) step(1'b0, '0);
        out_ready = 1'b1;
        mark();
        repeat (4) step(1'b0, '0);
        check("err_entries", pops, 2);
        mark();
        repeat (8) step(1'b0, '0);
        check("err_halt_req", req_fires, 0);
        check("err_halt_out", out_valid, 0);

        // Redirect coinciding with a response and a ready consumer at full credit.
        err_pc    = NO_ERR;
        out_ready = 1'b0;
        resp_hold = 1'b1;
        step(1'b1, 64'h8000_4000);
        repeat (5) step(1'b0, '0);
        resp_hold = 1'b0;
        repeat (2) step(1'b0, '0);
        out_ready = 1'b1;
        mark();
        step(1'b1, 64'h8000_5000);
        check("combo_empty", out_valid, 0);
        repeat (10) step(1'b0, '0);
        check("combo_first_pc", first_pc, 64'h8000_5000);

        // Reset mid-burst.
        repeat (4) step(1'b0, '0);
        rst_n = 1'b0;
        #1 check_quiet("midreset");
        pend.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_restart(RESET_PC);
        #1;
        check("rerun_req_valid", fetch_req_valid, 1);
        check("rerun_req_addr", fetch_req_addr, RESET_PC);
        mark();
        repeat (6) step(1'b0, '0);
        check("rerun_first_pc", first_pc, RESET_PC);

        // Randomized traffic, redirects and faults.
        resp_rand  = 70;
        total_pops = 0;
        for (int i = 0; i < 800; i++) begin
            fetch_req_ready = ($urandom_range(0, 3) != 0);
            out_ready       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                rpc = 64'h8000_0000 + 64'($urandom_range(0, 63)) * 64'd4 +
                      (($urandom_range(0, 7) == 0) ? 64'd2 : 64'd0);
                err_pc = ($urandom_range(0, 1) != 0) ? rpc + 64'($urandom_range(0, 7)) * 64'd4 : NO_ERR;
                step(1'b1, rpc);
            end else begin
                step(1'b0, '0);
            end
        end
        check("random_progress", 64'(total_pops >= 50), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
